// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run/halt/step controller.
// Used by the interface, the debounce sub-module and the top cpu_run_ctrl.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } run_state_e;

    localparam int CYC_CNT_W = 16;

    // Free-running wrap: 16'hFFFF + 1 -> 16'h0000, no carry out.
    function automatic logic [CYC_CNT_W-1:0] cyc_inc(input logic [CYC_CNT_W-1:0] c);
        return c + 1'b1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board-side signal bundle for cpu_run_ctrl: raw buttons and PC in, clock-enable and status out.
// The master side (board top / bench) drives buttons and pc; the slave side is the controller.
interface cpu_run_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic                 btn_stop;
    logic                 btn_step;
    logic [31:0]          pc;
    logic                 cpu_en;
    logic                 halted;
    logic [CYC_CNT_W-1:0] cyc_cnt;
    run_state_e           dbg_state;
    logic                 dbg_stop_level;
    logic                 dbg_step_level;

    modport master (
        output btn_stop, btn_step, pc,
        input  cpu_en, halted, cyc_cnt, dbg_state, dbg_stop_level, dbg_step_level
    );

    modport slave (
        input  btn_stop, btn_step, pc,
        output cpu_en, halted, cyc_cnt, dbg_state, dbg_stop_level, dbg_step_level
    );

endinterface

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, debounced level and
// a one-cycle press pulse on the debounced rising edge (raw edge to pulse = 2+DEBOUNCE_CYCLES).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // The counter only runs while the synced sample disagrees with the accepted level;
    // any sample equal to the level means the input bounced back, so the count restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller driving the CPU clock-enable and an enabled-cycle counter.
// Optional PC breakpoint is built only when the CPU_BRK_EN macro is defined.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          START_RUN       = 1'b1,
    parameter logic [31:0] BRK_ADDR        = 32'h0000_0040
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_run_ctrl_if.slave bus
);

    localparam run_state_e RESET_STATE = START_RUN ? RUN : HALT;

    logic                 w_stop_press;
    logic                 w_step_press;
    logic                 w_stop_level;
    logic                 w_step_level;
    logic                 w_bp_hit;
    logic                 w_cpu_en;
    run_state_e           r_state;
    logic [CYC_CNT_W-1:0] r_cyc_cnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_stop_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_stop),
        .level (w_stop_level),
        .press (w_stop_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_step),
        .level (w_step_level),
        .press (w_step_press)
    );

`ifdef CPU_BRK_EN
    logic r_resume;

    // r_resume masks the breakpoint for the first RUN cycle after a resume, so the
    // instruction parked at BRK_ADDR gets executed instead of re-triggering the halt.
    assign w_bp_hit = (r_state == RUN) && (bus.pc == BRK_ADDR) && !r_resume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resume <= 1'b0;
        end else if ((r_state == HALT) && w_stop_press) begin
            r_resume <= 1'b1;
        end else if (r_state == RUN) begin
            r_resume <= 1'b0;
        end
    end
`else
    logic w_unused_pc;

    assign w_bp_hit    = 1'b0;
    assign w_unused_pc = ^{bus.pc, BRK_ADDR};
`endif

    assign w_cpu_en = ((r_state == RUN) && !w_bp_hit) || (r_state == STEP);

    // Stop has priority over step in HALT; STEP always lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RESET_STATE;
            r_cyc_cnt <= '0;
        end else begin
            if (w_cpu_en) begin
                r_cyc_cnt <= cyc_inc(r_cyc_cnt);
            end
            case (r_state)
                RUN: begin
                    if (w_stop_press || w_bp_hit) begin
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    if (w_stop_press) begin
                        r_state <= RUN;
                    end else if (w_step_press) begin
                        r_state <= STEP;
                    end
                end
                STEP:    r_state <= HALT;
                default: r_state <= HALT;
            endcase
        end
    end

    assign bus.cpu_en         = w_cpu_en;
    assign bus.halted         = (r_state == HALT);
    assign bus.cyc_cnt        = r_cyc_cnt;
    assign bus.dbg_state      = r_state;
    assign bus.dbg_stop_level = w_stop_level;
    assign bus.dbg_step_level = w_step_level;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4 and START_RUN=1.
// Breakpoint sequence is compiled in only when CPU_BRK_EN is defined.
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

    typedef struct {
        logic  stop;
        logic  step;
        int    hold;
        int    settle;
        logic  exp_en;
        logic  exp_halted;
        int    delta;
        string name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    int   exp_cnt;
    vec_t vecs[8];

    cpu_run_ctrl_if bus();

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .START_RUN       (1'b1),
        .BRK_ADDR        (32'h0000_0040)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic stop, input logic step, input int hold,
                                input int settle, input logic exp_en, input logic exp_halted,
                                input int delta, input string name);
        vec_t v;
        v.stop = stop; v.step = step; v.hold = hold; v.settle = settle;
        v.exp_en = exp_en; v.exp_halted = exp_halted; v.delta = delta; v.name = name;
        return v;
    endfunction

    // A press of 'hold' cycles followed by 'settle' idle cycles; delta is the number of
    // enabled cycles over that window, worked out from the 2+4+1 press-to-state latency.
    task automatic apply_vec(input vec_t v);
        bus.btn_stop = v.stop;
        bus.btn_step = v.step;
        tick(v.hold);
        bus.btn_stop = 1'b0;
        bus.btn_step = 1'b0;
        tick(v.settle);
        exp_cnt = (exp_cnt + v.delta) % 65536;
        check({v.name, " cpu_en"},  32'(bus.cpu_en),  32'(v.exp_en));
        check({v.name, " halted"},  32'(bus.halted),  32'(v.exp_halted));
        check({v.name, " cyc_cnt"}, 32'(bus.cyc_cnt), exp_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        exp_cnt  = 0;

        vecs[0] = mk(1'b1, 1'b0,  3, 17, 1'b1, 1'b0, 20, "stop_glitch");
        vecs[1] = mk(1'b1, 1'b0, 10, 10, 1'b0, 1'b1,  7, "run_to_halt");
        vecs[2] = mk(1'b0, 1'b1, 10, 10, 1'b0, 1'b1,  1, "step_a");
        vecs[3] = mk(1'b0, 1'b1, 10, 10, 1'b0, 1'b1,  1, "step_b");
        vecs[4] = mk(1'b1, 1'b0, 10, 10, 1'b1, 1'b0, 13, "halt_to_run");
        vecs[5] = mk(1'b0, 1'b1, 10, 10, 1'b1, 1'b0, 20, "step_in_run");
        vecs[6] = mk(1'b1, 1'b0, 10, 10, 1'b0, 1'b1,  7, "run_to_halt2");
        vecs[7] = mk(1'b1, 1'b1, 10, 10, 1'b1, 1'b0, 13, "both_in_halt");

        rst_n        = 1'b0;
        bus.btn_stop = 1'b0;
        bus.btn_step = 1'b0;
        bus.pc       = 32'h0;
        tick(3);
        check("rst cpu_en",  32'(bus.cpu_en),    32'd1);
        check("rst halted",  32'(bus.halted),    32'd0);
        check("rst cyc_cnt", 32'(bus.cyc_cnt),   32'd0);
        check("rst state",   32'(bus.dbg_state), 32'(RUN));

        rst_n = 1'b1;
        tick(10);
        exp_cnt = 10;
        check("run10 cyc_cnt", 32'(bus.cyc_cnt), exp_cnt);

`ifndef CPU_BRK_EN
        bus.pc = 32'h0000_0040;
        tick(3);
        exp_cnt += 3;
        check("nobrk cpu_en",  32'(bus.cpu_en),  32'd1);
        check("nobrk halted",  32'(bus.halted),  32'd0);
        check("nobrk cyc_cnt", 32'(bus.cyc_cnt), exp_cnt);
        bus.pc = 32'h0;
`endif

        for (int i = 0; i < 8; i++) begin
            apply_vec(vecs[i]);
        end

        // Stop latency: pulse after edge 6, HALT after edge 7.
        bus.btn_stop = 1'b1;
        tick(6);
        check("lat6 halted", 32'(bus.halted), 32'd0);
        check("lat6 cpu_en", 32'(bus.cpu_en), 32'd1);
        check("lat6 level",  32'(bus.dbg_stop_level), 32'd1);
        tick(1);
        check("lat7 halted", 32'(bus.halted), 32'd1);
        check("lat7 cpu_en", 32'(bus.cpu_en), 32'd0);
        exp_cnt += 7;
        tick(3);
        bus.btn_stop = 1'b0;
        tick(10);
        check("lat cyc_cnt", 32'(bus.cyc_cnt), exp_cnt);

        // Single step is exactly one enabled cycle.
        bus.btn_step = 1'b1;
        tick(6);
        check("step6 cpu_en", 32'(bus.cpu_en), 32'd0);
        tick(1);
        check("step7 cpu_en", 32'(bus.cpu_en),    32'd1);
        check("step7 halted", 32'(bus.halted),    32'd0);
        check("step7 state",  32'(bus.dbg_state), 32'(STEP));
        tick(1);
        check("step8 cpu_en", 32'(bus.cpu_en), 32'd0);
        check("step8 halted", 32'(bus.halted), 32'd1);
        exp_cnt += 1;
        tick(2);
        bus.btn_step = 1'b0;
        tick(10);
        check("step cyc_cnt", 32'(bus.cyc_cnt), exp_cnt);

        apply_vec(mk(1'b1, 1'b0, 10, 10, 1'b1, 1'b0, 13, "resume_for_wrap"));

        // Counter wrap.
        tick(65535 - exp_cnt);
        check("wrap ffff", 32'(bus.cyc_cnt), 32'h0000_FFFF);
        tick(1);
        check("wrap 0000", 32'(bus.cyc_cnt), 32'h0);
        exp_cnt = 0;

        apply_vec(mk(1'b1, 1'b0, 10, 10, 1'b0, 1'b1, 7, "halt_after_wrap"));

        // Reset in the middle of a STEP cycle.
        bus.btn_step = 1'b1;
        tick(7);
        check("pre_rst step", 32'(bus.dbg_state), 32'(STEP));
        rst_n = 1'b0;
        #1;
        check("midstep cpu_en",  32'(bus.cpu_en),    32'd1);
        check("midstep halted",  32'(bus.halted),    32'd0);
        check("midstep cyc_cnt", 32'(bus.cyc_cnt),   32'd0);
        check("midstep state",   32'(bus.dbg_state), 32'(RUN));
        bus.btn_step = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("post_rst cyc_cnt", 32'(bus.cyc_cnt), 32'd10);
        check("post_rst halted",  32'(bus.halted),  32'd0);

        // Reset during a partial debounce must restart the full latency.
        bus.btn_stop = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick(6);
        check("partial6 halted", 32'(bus.halted), 32'd0);
        tick(1);
        check("partial7 halted",  32'(bus.halted),  32'd1);
        check("partial7 cyc_cnt", 32'(bus.cyc_cnt), 32'd7);
        bus.btn_stop = 1'b0;
        tick(10);

`ifdef CPU_BRK_EN
        rst_n = 1'b0;
        tick(1);
        bus.pc = 32'h0000_003C;
        rst_n  = 1'b1;
        check("brk 3c cpu_en", 32'(bus.cpu_en), 32'd1);
        tick(2);
        check("brk 3c cyc_cnt", 32'(bus.cyc_cnt), 32'd2);
        bus.pc = 32'h0000_0040;
        #1;
        check("brk hit cpu_en", 32'(bus.cpu_en), 32'd0);
        check("brk hit halted", 32'(bus.halted), 32'd0);
        tick(1);
        check("brk halted",  32'(bus.halted),  32'd1);
        check("brk cpu_en",  32'(bus.cpu_en),  32'd0);
        check("brk cyc_cnt", 32'(bus.cyc_cnt), 32'd2);

        bus.btn_step = 1'b1;
        tick(7);
        check("brk step cpu_en", 32'(bus.cpu_en), 32'd1);
        tick(1);
        check("brk step halted",  32'(bus.halted),  32'd1);
        check("brk step cyc_cnt", 32'(bus.cyc_cnt), 32'd3);
        tick(2);
        bus.btn_step = 1'b0;
        tick(10);

        bus.btn_stop = 1'b1;
        tick(7);
        check("brk resume cpu_en", 32'(bus.cpu_en), 32'd1);
        check("brk resume halted", 32'(bus.halted), 32'd0);
        tick(1);
        bus.pc = 32'h0000_0044;
        #1;
        check("brk next cpu_en",  32'(bus.cpu_en),  32'd1);
        check("brk next halted",  32'(bus.halted),  32'd0);
        check("brk next cyc_cnt", 32'(bus.cyc_cnt), 32'd4);
        bus.btn_stop = 1'b0;
        tick(10);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
